hazard_scoreboard: RTL and testbench

- Producer-side companion to the operand forwarding logic.
- Records every in-flight register write whose result is not yet available on a forwarding path: loads with a fixed latency, and one outstanding long-latency op (mul/div).
- Asserts stall to the ID stage until the producer's value can be forwarded.
- Sits between decode (issue side) and the long-op unit (completion side).

---
 rtl/hazard_scoreboard.sv | 145 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load/long-op hazard scoreboard that stalls ID until a producer is forwardable
//
// Optional feature macro: SB_LO_BYPASS_EN (long-op completion bus is forwardable)
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   issue_valid       ID presents an instruction
//   issue_rd          destination register
//   issue_regwrite    instruction writes rd
//   issue_kind        00 ALU, 01 load, 10 long op, 11 reserved (ALU)
//   use_rs1, rs1      first source operand used / index
//   use_rs2, rs2      second source operand used / index
//   lo_done, lo_rd    long-op unit completion strobe and its destination
//   stall             hold ID/IF and inject a bubble; the issue is not recorded
//   busy_mask         registered pending bit per register (bit 0 always 0)
//   lo_busy           a long op is outstanding
module hazard_scoreboard #(
   parameter int LOAD_LAT = 2,
   parameter int CNT_W    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic        issue_regwrite,
   input  logic [1:0]  issue_kind,
   input  logic        use_rs1,
   input  logic        use_rs2,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic        lo_done,
   input  logic [4:0]  lo_rd,
   output logic        stall,
   output logic [31:0] busy_mask,
   output logic        lo_busy
);

   logic [31:0]      pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];
   logic             lo_busy_q, lo_busy_d;
   logic [4:0]       lo_tag_q, lo_tag_d;

   logic             lo_complete;
   logic [31:0]      fwd_mask;
   logic [31:0]      raw_pending;
   logic             haz, waw, strct, accept;
   logic             is_load, is_long;

   assign lo_complete = lo_done && lo_busy_q;

`ifdef SB_LO_BYPASS_EN
   // The completing long-op result is on the forwarding bus this cycle, so
   // readers of its destination need not wait for the pending bit to drop.
   always_comb begin
      fwd_mask = 32'h0;
      if (lo_complete) begin
         fwd_mask[lo_rd] = 1'b1;
      end
   end
`else
   logic unused_lo_rd;
   assign fwd_mask     = 32'h0;
   assign unused_lo_rd = ^lo_rd;
`endif

   // Forwarding only resolves RAW hazards; WAW still sees the raw pending bit.
   assign raw_pending = pending_q & ~fwd_mask;

   assign haz    = (use_rs1 && (rs1 != 5'd0) && raw_pending[rs1]) ||
                   (use_rs2 && (rs2 != 5'd0) && raw_pending[rs2]);
   assign waw    = issue_regwrite && (issue_rd != 5'd0) && pending_q[issue_rd];
   assign strct  = (issue_kind == 2'b10) && lo_busy_q;
   assign stall  = issue_valid && (haz || waw || strct);
   assign accept = issue_valid && !stall;

   assign is_load = (issue_kind == 2'b01);
   assign is_long = (issue_kind == 2'b10);

   always_comb begin
      pending_d = pending_q;
      cnt_d     = cnt_q;
      lo_busy_d = lo_busy_q;
      lo_tag_d  = lo_tag_q;

      // Load entries count down; the entry retires as the counter leaves 1.
      // Long-op entries hold cnt=0 and therefore never count.
      for (int r = 1; r < 32; r++) begin
         if (pending_q[r] && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
            if (cnt_q[r] == CNT_W'(1)) begin
               pending_d[r] = 1'b0;
            end
         end
      end

      if (lo_complete) begin
         lo_busy_d = 1'b0;
         if (lo_tag_q != 5'd0) begin
            pending_d[lo_tag_q] = 1'b0;
         end
      end

      // An accepted issue never targets a pending rd (WAW stalls it), and a
      // long op is never accepted while one is busy, so these cannot collide
      // with the retire paths above.
      if (accept && is_load && issue_regwrite && (issue_rd != 5'd0)) begin
         pending_d[issue_rd] = 1'b1;
         cnt_d[issue_rd]     = CNT_W'(LOAD_LAT);
      end

      if (accept && is_long) begin
         lo_busy_d = 1'b1;
         lo_tag_d  = issue_rd;
         if (issue_regwrite && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
            cnt_d[issue_rd]     = '0;
         end
      end

      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         lo_busy_q <= 1'b0;
         lo_tag_q  <= 5'd0;
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         pending_q <= pending_d;
         lo_busy_q <= lo_busy_d;
         lo_tag_q  <= lo_tag_d;
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   assign busy_mask = pending_q;
   assign lo_busy   = lo_busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

   localparam int LOAD_LAT = 2;
`ifdef SB_LO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_regwrite;
   logic [1:0]  issue_kind;
   logic        use_rs1;
   logic        use_rs2;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        lo_done;
   logic [4:0]  lo_rd;
   logic        stall;
   logic [31:0] busy_mask;
   logic        lo_busy;

   int checks = 0;
   int errors = 0;

   // Reference model: a load's register is pending while cyc < ready_time;
   // a long op's register is pending until its completion is seen.
   int unsigned cyc = 0;
   int unsigned ready_time [32];
   bit          lo_pend [32];
   bit          m_lo_busy;
   logic [4:0]  m_lo_tag;

   hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_regwrite(issue_regwrite), .issue_kind(issue_kind),
      .use_rs1(use_rs1), .use_rs2(use_rs2), .rs1(rs1), .rs2(rs2),
      .lo_done(lo_done), .lo_rd(lo_rd),
      .stall(stall), .busy_mask(busy_mask), .lo_busy(lo_busy)
   );

   always #5 clk = ~clk;

   function automatic bit m_pend(input int r);
      if (r == 0) return 1'b0;
      return (ready_time[r] > cyc) || lo_pend[r];
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m;
      for (int r = 0; r < 32; r++) m[r] = m_pend(r);
      return m;
   endfunction

   function automatic bit m_reads(input bit u, input logic [4:0] s);
      if (!u || s == 5'd0 || !m_pend(s)) return 1'b0;
      if (BYPASS && lo_done && m_lo_busy && s == m_lo_tag) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_stall();
      bit h, w, st;
      h  = m_reads(use_rs1, rs1) || m_reads(use_rs2, rs2);
      w  = issue_regwrite && issue_rd != 5'd0 && m_pend(issue_rd);
      st = issue_kind == 2'b10 && m_lo_busy;
      return issue_valid && (h || w || st);
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 32; r++) begin
         ready_time[r] = 0;
         lo_pend[r]    = 1'b0;
      end
      m_lo_busy = 1'b0;
      m_lo_tag  = 5'd0;
   endtask

   task automatic m_update(input bit acc);
      if (lo_done && m_lo_busy) begin
         m_lo_busy = 1'b0;
         if (m_lo_tag != 5'd0) begin
            ready_time[m_lo_tag] = 0;
            lo_pend[m_lo_tag]    = 1'b0;
         end
      end
      if (acc && issue_kind == 2'b01 && issue_regwrite && issue_rd != 5'd0)
         ready_time[issue_rd] = cyc + 1 + LOAD_LAT;
      if (acc && issue_kind == 2'b10) begin
         m_lo_busy = 1'b1;
         m_lo_tag  = issue_rd;
         if (issue_regwrite && issue_rd != 5'd0) lo_pend[issue_rd] = 1'b1;
      end
      cyc++;
   endtask

   task automatic drive(input bit v, input logic [1:0] k, input logic [4:0] rd, input bit rw,
                        input bit u1, input logic [4:0] a, input bit u2, input logic [4:0] b);
      issue_valid = v; issue_kind = k; issue_rd = rd; issue_regwrite = rw;
      use_rs1 = u1; rs1 = a; use_rs2 = u2; rs2 = b;
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
   endtask

   // One cycle: check outputs against the model (and an optional directed
   // stall value), then advance the model across the clock edge.
   task automatic tick(input int want);
      bit          es;
      logic [31:0] em;
      #1;
      es = m_stall();
      em = m_mask();
      checks++;
      assert (stall === es) else begin
         errors++;
         $error("FAIL stall cyc=%0d obs=%0b exp=%0b", cyc, stall, es);
      end
      checks++;
      assert (busy_mask === em) else begin
         errors++;
         $error("FAIL busy_mask cyc=%0d obs=%h exp=%h", cyc, busy_mask, em);
      end
      checks++;
      assert (lo_busy === m_lo_busy) else begin
         errors++;
         $error("FAIL lo_busy cyc=%0d obs=%0b exp=%0b", cyc, lo_busy, m_lo_busy);
      end
      if (want >= 0) begin
         checks++;
         assert (stall === want[0]) else begin
            errors++;
            $error("FAIL directed_stall cyc=%0d obs=%0b exp=%0b", cyc, stall, want[0]);
         end
      end
      @(posedge clk);
      m_update(issue_valid && !es);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      m_clear();
      cyc++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      idle();
      lo_done = 1'b0;
      lo_rd   = 5'd0;
      m_clear();
      do_reset();
      do_reset();

      // Reset state, then load x5 followed by a dependent reader.
      tick(0);
      drive(1, 2'b01, 5'd5, 1, 0, 5'd0, 0, 5'd0); tick(0);
      drive(1, 2'b00, 5'd6, 1, 1, 5'd5, 0, 5'd0); tick(1);
      tick(1);
      tick(0);
      idle(); tick(0);

      // x0 is never tracked.
      drive(1, 2'b01, 5'd0, 1, 0, 5'd0, 0, 5'd0); tick(0);
      drive(1, 2'b00, 5'd4, 1, 1, 5'd0, 1, 5'd0); tick(0);

      // Long op x7 with a reader of rs2=7 waiting for completion.
      drive(1, 2'b10, 5'd7, 1, 0, 5'd0, 0, 5'd0); tick(0);
      drive(1, 2'b00, 5'd4, 1, 0, 5'd0, 1, 5'd7);
      for (int i = 0; i < 4; i++) tick(1);
      lo_done = 1'b1; lo_rd = 5'd7; tick(BYPASS ? 0 : 1);
      lo_done = 1'b0; tick(0);
      idle(); tick(0);

      // Second long op is structurally stalled until the cycle after lo_done.
      drive(1, 2'b10, 5'd8, 1, 0, 5'd0, 0, 5'd0); tick(0);
      drive(1, 2'b10, 5'd9, 1, 0, 5'd0, 0, 5'd0); tick(1);
      tick(1);
      lo_done = 1'b1; lo_rd = 5'd8; tick(1);
      lo_done = 1'b0; tick(0);
      idle(); tick(0);
      lo_done = 1'b1; lo_rd = 5'd9; tick(0);
      lo_done = 1'b0; tick(0);

      // WAW on an outstanding load, then reset with entries in flight.
      drive(1, 2'b01, 5'd3, 1, 0, 5'd0, 0, 5'd0); tick(0);
      tick(1);
      tick(1);
      tick(0);
      drive(1, 2'b10, 5'd9, 1, 0, 5'd0, 0, 5'd0); tick(0);
      idle();
      do_reset();
      tick(0);
      lo_done = 1'b1; lo_rd = 5'd9; tick(0);
      lo_done = 1'b0; tick(0);

      // Randomized traffic on a small register window to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 4) != 0, 2'($urandom % 4), 5'($urandom % 8), ($urandom % 4) != 0,
               1'($urandom % 2), 5'($urandom % 8), 1'($urandom % 2), 5'($urandom % 8));
         if (m_lo_busy && ($urandom % 4) == 0) begin
            lo_done = 1'b1; lo_rd = m_lo_tag;
         end else if (!m_lo_busy && ($urandom % 16) == 0) begin
            lo_done = 1'b1; lo_rd = 5'($urandom % 32);
         end else begin
            lo_done = 1'b0; lo_rd = 5'd0;
         end
         if (($urandom % 150) == 0) begin
            do_reset();
         end else begin
            tick(-1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
